risc_lsu: RTL and testbench

RISC_LSU -- requirements
Module: risc_lsu

---
 rtl/risc_pkg.sv | 40 ++++
 rtl/risc_lsu_if.sv | 46 ++++
 rtl/risc_lsu_align.sv | 34 +++
 rtl/risc_lsu.sv | 140 ++++++++++++++
 tb/tb_risc_lsu.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the load/store unit.
package risc_pkg;

  // Load/store unit sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // funct3 encodings: size in [1:0], unsigned-load flag in [2].
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bus cycles to wait for an ack before declaring a bus error.
  localparam int LSU_TIMEOUT = 255;

  // An op is legal when exactly one of read/write is set, funct3 names an
  // access that exists for that direction, and the address is naturally aligned.
  function automatic logic lsu_op_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic f3_ok;
    logic align_ok;
    if (wr) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b01:   align_ok = ~lo[0];
      2'b10:   align_ok = (lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return (rd ^ wr) && f3_ok && align_ok;
  endfunction

endpackage

// File: rtl/risc_lsu_if.sv
// Signal bundle between the pipeline/memory and the load/store unit.
//
// Bus handshake: dmem_req rises with dmem_addr/dmem_be/dmem_we/dmem_wdata
// already valid and those stay stable for as long as dmem_req is high. The
// transfer completes in the first cycle where dmem_req and dmem_ack are both
// high; dmem_rdata is sampled in that same cycle. dmem_req drops in the cycle
// after completion (or after a wait timeout).
interface risc_lsu_if
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  // pipeline side
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] dmem_data_out;
  logic                  stall;
  logic                  lsu_err;
  // memory bus side
  logic                  dmem_req;
  logic                  dmem_we;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  // debug view of the sequencing FSM
  lsu_state_t            lsu_state;

  // The LSU: consumes pipeline requests, masters the memory bus.
  modport master (
    input  mem_read, mem_write, funct3, addr, store_data, dmem_ack, dmem_rdata,
    output dmem_data_out, stall, lsu_err, dmem_req, dmem_we, dmem_be,
           dmem_addr, dmem_wdata, lsu_state
  );

  // The surroundings: pipeline control plus the data memory.
  modport slave (
    output mem_read, mem_write, funct3, addr, store_data, dmem_ack, dmem_rdata,
    input  dmem_data_out, stall, lsu_err, dmem_req, dmem_we, dmem_be,
           dmem_addr, dmem_wdata, lsu_state
  );
endinterface

// File: rtl/risc_lsu_align.sv
// Load lane extraction and sign/zero extension (purely combinational).
module risc_lsu_align
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_lane,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/half from the bus word and extend it.
  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_H:    o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/risc_lsu.sv
// Load/store unit: validates pipeline memory ops, runs one bus transfer per
// op with a wait timeout, and holds the last load result for writeback.
module risc_lsu
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = LSU_TIMEOUT
) (
  input logic        clk,
  input logic        nrst,
  risc_lsu_if.master bus
);

  lsu_state_t            r_state;
  lsu_state_t            w_next;
  logic [31:0]           r_wait;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_lane;
  logic [2:0]            r_funct3;
  logic [3:0]            r_be;
  logic                  r_we;
  logic                  r_err;

  logic                  w_op;
  logic                  w_legal;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_ack;
  logic                  w_timeout;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_op      = bus.mem_read | bus.mem_write;
  assign w_legal   = lsu_op_legal(bus.mem_read, bus.mem_write, bus.funct3, bus.addr[1:0]);
  assign w_accept  = (r_state == IDLE) && w_op && w_legal;
  assign w_illegal = (r_state == IDLE) && w_op && !w_legal;
  assign w_ack     = (r_state == BUSY) && bus.dmem_ack;
  // Last permitted wait cycle passed without an ack; an ack in that cycle wins.
  assign w_timeout = (r_state == BUSY) && !bus.dmem_ack && (r_wait == 32'(TIMEOUT - 1));

  // Lane mask and lane-replicated write data for the requested access size.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.store_data;
    case (bus.funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr[1:0];
        w_wdata = {(DATA_WIDTH/8){bus.store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << bus.addr[1:0];
        w_wdata = {(DATA_WIDTH/16){bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  risc_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_rdata  (bus.dmem_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_data   (w_load)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (w_ack || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: hold the pipeline from acceptance until the bus completes.
  always_comb begin
    bus.stall    = 1'b0;
    bus.dmem_req = 1'b0;
    case (r_state)
      IDLE:    bus.stall = w_accept;
      BUSY: begin
        bus.stall    = 1'b1;
        bus.dmem_req = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch the request on accept, count waits, capture load data.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wait   <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lane   <= '0;
      r_funct3 <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_illegal | w_timeout;
      if (w_accept) begin
        r_addr   <= {bus.addr[DATA_WIDTH-1:2], 2'b00};
        r_lane   <= bus.addr[1:0];
        r_funct3 <= bus.funct3;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_we     <= bus.mem_write;
        r_wait   <= '0;
      end
      if (w_ack) begin
        if (!r_we) r_data <= w_load;
      end else if (w_timeout) begin
        r_data <= '0;
      end else if (r_state == BUSY) begin
        r_wait <= r_wait + 32'd1;
      end
    end
  end

  assign bus.dmem_data_out = r_data;
  assign bus.dmem_we       = r_we;
  assign bus.dmem_be       = r_be;
  assign bus.dmem_addr     = r_addr;
  assign bus.dmem_wdata    = r_wdata;
  assign bus.lsu_err       = r_err;
  assign bus.lsu_state     = r_state;

endmodule

// File: tb/tb_risc_lsu.sv
// Self-checking bench for risc_lsu: directed cases plus randomized accesses
// against a behavioural model of the load/store rules.
module tb_risc_lsu;
  import risc_pkg::*;

  localparam int DW  = 32;
  localparam int TMO = LSU_TIMEOUT;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  risc_lsu_if #(.DATA_WIDTH(DW)) bus ();

  risc_lsu #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_data = '0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a);
    if (rd == wr) return 1'b0;
    if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
    if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int lo;
    be = '0;
    lo = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + acc_size(f3)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % acc_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    byte         b;
    shortint     h;
    sh = rd >> (8 * (a % 4));
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  return 32'(int'(b));
      3'b001:  return 32'(int'(h));
      3'b100:  return sh & 32'h0000_00FF;
      3'b101:  return sh & 32'h0000_FFFF;
      default: return rd;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = '0;
    bus.store_data = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
  task automatic idle_cycle();
    idle_inputs();
    #1;
    chk("noop_stall", bus.stall, 0);
    chk("noop_req", bus.dmem_req, 0);
    @(posedge clk); #1;
    chk("noop_err", bus.lsu_err, 0);
    chk("noop_data_hold", bus.dmem_data_out, model_data);
  endtask

  // delay = BUSY cycles before ack (0 = ack in first BUSY cycle); <0 = never ack.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int delay, input logic [31:0] rdat);
    logic        legal;
    logic        to;
    logic        ended;
    int          n_busy;
    logic [31:0] exp_d;
    legal          = ref_legal(rd, wr, f3, a);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
    #1;
    if (!legal) begin
      chk("ill_stall", bus.stall, 0);
      chk("ill_req", bus.dmem_req, 0);
      @(posedge clk); #1;
      chk("ill_err", bus.lsu_err, 1);
      chk("ill_req_next", bus.dmem_req, 0);
      chk("ill_stall_next", bus.stall, 0);
      chk("ill_state", 32'(bus.lsu_state), 32'(IDLE));
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      @(posedge clk); #1;
      chk("ill_err_clear", bus.lsu_err, 0);
      chk("ill_data_hold", bus.dmem_data_out, model_data);
    end else begin
      to = (delay < 0);
      if (to)      exp_d = '0;
      else if (rd) exp_d = ref_load(f3, a, rdat);
      else         exp_d = model_data;
      exp_q.push_back(exp_d);
      chk("acc_stall_idle", bus.stall, 1);
      chk("acc_req_idle", bus.dmem_req, 0);
      @(posedge clk); #1;
      n_busy = 0;
      ended  = 1'b0;
      while (!ended && n_busy < TMO + 4) begin
        chk("busy_req", bus.dmem_req, 1);
        chk("busy_stall", bus.stall, 1);
        chk("busy_addr", bus.dmem_addr, a & 32'hFFFF_FFFC);
        chk("busy_we", bus.dmem_we, wr);
        if (wr) begin
          chk("busy_be", bus.dmem_be, ref_be(f3, a));
          chk("busy_wdata", bus.dmem_wdata, ref_wdata(f3, sd));
        end
        if (!to && n_busy == delay) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdat;
        end else begin
          bus.dmem_ack   = 1'b0;
          bus.dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        n_busy++;
        if (!bus.dmem_req) ended = 1'b1;
      end
      chk("busy_len", n_busy, to ? TMO : delay + 1);
      chk("done_state", 32'(bus.lsu_state), 32'(DONE));
      chk("done_stall", bus.stall, 0);
      chk("done_err", bus.lsu_err, to);
      model_data = exp_d;
      chk("done_data", bus.dmem_data_out, exp_q.pop_front());
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      @(posedge clk); #1;
      chk("post_state", 32'(bus.lsu_state), 32'(IDLE));
      chk("post_err", bus.lsu_err, 0);
      chk("post_stall", bus.stall, 0);
      chk("post_data_hold", bus.dmem_data_out, model_data);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.lsu_state), 32'(IDLE));
    chk("rst_data", bus.dmem_data_out, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_err", bus.lsu_err, 0);
    chk("rst_be", bus.dmem_be, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_we", bus.dmem_we, 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    idle_cycle();

    // LW with immediate ack
    run_access(1, 0, F3_W, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lw_data", bus.dmem_data_out, 32'hDEAD_BEEF);
    chk("lw_addr", bus.dmem_addr, 32'h100);
    // byte/half extraction
    run_access(1, 0, F3_B, 32'h103, 32'h0, 1, 32'h80FF_0000);
    chk("lb_data", bus.dmem_data_out, 32'hFFFF_FF80);
    run_access(1, 0, F3_BU, 32'h103, 32'h0, 0, 32'h80FF_0000);
    chk("lbu_data", bus.dmem_data_out, 32'h0000_0080);
    run_access(1, 0, F3_H, 32'h102, 32'h0, 2, 32'h80FF_0000);
    chk("lh_data", bus.dmem_data_out, 32'hFFFF_80FF);
    // SH lane placement; load result untouched
    run_access(0, 1, F3_H, 32'h0A2, 32'h1234_ABCD, 0, 32'h0);
    chk("sh_be", bus.dmem_be, 4'b1100);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", bus.dmem_we, 1);
    chk("sh_data_kept", bus.dmem_data_out, 32'hFFFF_80FF);
    run_access(0, 1, F3_B, 32'h0A1, 32'h0000_005A, 1, 32'h0);
    chk("sb_be", bus.dmem_be, 4'b0010);
    chk("sb_wdata", bus.dmem_wdata, 32'h5A5A_5A5A);
    // illegal ops
    run_access(1, 0, F3_W, 32'h101, 32'h0, 0, 32'h0);
    run_access(1, 0, F3_H, 32'h103, 32'h0, 0, 32'h0);
    run_access(1, 1, F3_W, 32'h100, 32'h0, 0, 32'h0);
    run_access(0, 1, F3_BU, 32'h100, 32'h0, 0, 32'h0);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    run_access(1, 0, 3'b110, 32'h100, 32'h0, 0, 32'h0);
    chk("ill_data_kept", bus.dmem_data_out, 32'hFFFF_80FF);
    // timeout on a load
    run_access(1, 0, F3_W, 32'h200, 32'h0, -1, 32'h0);
    chk("to_data", bus.dmem_data_out, 32'h0);

    // reset in the third BUSY cycle, with an ack offered in that cycle
    run_access(1, 0, F3_LW_DUMMY_GUARD(), 32'h104, 32'h0, 0, 32'h1357_9BDF);
    bus.mem_read   = 1'b1;
    bus.funct3     = F3_W;
    bus.addr       = 32'h300;
    bus.store_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy_req", bus.dmem_req, 1);
    nrst           = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    bus.mem_read   = 1'b0;
    @(posedge clk); #1;
    chk("rstb_req", bus.dmem_req, 0);
    chk("rstb_state", 32'(bus.lsu_state), 32'(IDLE));
    chk("rstb_data", bus.dmem_data_out, 0);
    chk("rstb_be", bus.dmem_be, 0);
    chk("rstb_addr", bus.dmem_addr, 0);
    chk("rstb_wdata", bus.dmem_wdata, 0);
    chk("rstb_we", bus.dmem_we, 0);
    chk("rstb_err", bus.lsu_err, 0);
    chk("rstb_stall", bus.stall, 0);
    nrst       = 1'b1;
    model_data = '0;
    idle_inputs();
    @(posedge clk); #1;
    idle_cycle();

    // randomized accesses
    for (int i = 0; i < 200; i++) begin
      int          r;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        idle_cycle();
      end else begin
        rd = (r == 1) || (r < 9);
        wr = (r == 1) || (r >= 9);
        if ($urandom_range(0, 3) != 0) begin
          if (wr) f3 = 3'($urandom_range(0, 2));
          else begin
            r  = $urandom_range(0, 4);
            f3 = (r < 3) ? 3'(r) : 3'(r + 1);
          end
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
        run_access(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom);
      end
    end

    // store that times out also clears the held load value
    run_access(1, 0, F3_W, 32'h40, 32'h0, 0, 32'h2468_ACE0);
    run_access(0, 1, F3_W, 32'h44, 32'h1111_2222, -1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [2:0] F3_LW_DUMMY_GUARD();
    return F3_W;
  endfunction

endmodule
